sd_pkt_commit: RTL
==================

SD_PKT_COMMIT -- requirements
Module: sd_pkt_commit

Interface
REQ-001 SHALL have parameter width, default 8: data word width in bits.
REQ-002 SHALL have parameter max_len, default 1518: maximum packet length in words; legal range is max_len >= 2.
REQ-003 SHALL have parameter lsz, default $clog2(max_len+1): length counter width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 c_srdy  input  1  upstream word valid.
REQ-007 c_drdy  output  1  block accepts the upstream word.
REQ-008 c_data  input  width  upstream data.
REQ-009 c_eop  input  1  marks the last word of a packet; qualified by c_srdy.
REQ-010 c_err  input  1  packet error flag; sampled only on the eop word.
REQ-011 p_srdy  output  1  downstream word valid; drives the write side of a commit-enabled FIFO.
REQ-012 p_drdy  input  1  downstream ready.
REQ-013 p_data  output  width  downstream data; equals c_data.
REQ-014 p_commit  output  1  one-cycle pulse that commits the packet just written.
REQ-015 p_abort  output  1  one-cycle pulse that discards the packet just written.
REQ-016 pkt_count  output  16  count of committed packets; wraps at 2^16.
REQ-017 drop_count  output  16  count of aborted packets; wraps at 2^16.

Function
REQ-018 SHALL implement states IDLE, ACTIVE, COMMIT, ABORT and DROP, plus a drop_pend flag and a length counter len[lsz-1:0].
REQ-019 A transfer on either side SHALL occur in a cycle where both srdy and drdy of that side are high.
REQ-020 In IDLE and ACTIVE, when the word is not an overflow word: p_srdy = c_srdy and c_drdy = p_drdy, combinationally, with zero latency.
REQ-021 In COMMIT and ABORT: p_srdy = 0 and c_drdy = 0.
REQ-022 In DROP: c_drdy = 1 and p_srdy = 0; every upstream word is consumed and discarded.
REQ-023 An overflow word SHALL be any word presented in ACTIVE while len == max_len.
REQ-024 For an overflow word: p_srdy = 0 and c_drdy = 1, independent of p_drdy.
REQ-025 On a transferred word in IDLE, the next state SHALL be:
- eop with err = 0 -> COMMIT
- eop with err = 1 -> ABORT
- no eop -> ACTIVE with len = 1
REQ-026 On a forwarded word in ACTIVE, the next state SHALL be:
- eop -> COMMIT or ABORT, selected by c_err
- otherwise len increments and the state stays ACTIVE
REQ-027 On an overflow word, the next state SHALL be ABORT, and drop_pend SHALL be set to !c_eop.
REQ-028 COMMIT SHALL last exactly one cycle:
- p_commit = 1
- pkt_count increments
- next state IDLE
REQ-029 ABORT SHALL last exactly one cycle:
- p_abort = 1
- drop_count increments
- next state DROP if drop_pend, else IDLE
- drop_pend clears
REQ-030 In DROP, consuming an eop word SHALL return the state to IDLE; no further pulse or count change occurs.
REQ-031 p_commit and p_abort SHALL be registered outputs, SHALL never be high simultaneously, and SHALL be high only in COMMIT and ABORT respectively.
REQ-032 Each packet SHALL produce exactly one commit or abort pulse.
- The pulse occurs in the cycle after the packet's final forwarded (or overflow) word.
- A single-word packet is legal.
REQ-033 Upstream stall (c_srdy = 0) and downstream stall (p_drdy = 0) SHALL hold state, len and data unchanged.
REQ-034 len SHALL be reset to 0 on every entry to IDLE.

Reset
REQ-035 On reset = 1 at a clock edge, the next cycle SHALL have:
- state IDLE, len = 0, drop_pend = 0
- p_commit = 0, p_abort = 0
- pkt_count = 0, drop_count = 0
REQ-036 While reset = 1, c_drdy and p_srdy SHALL be 0.
REQ-037 Reset mid-packet SHALL discard the partial packet without a commit or abort pulse; the downstream FIFO is reset alongside.

Verification
REQ-038 4-word packet, err = 0, p_drdy = 1 -> 4 words forwarded, p_commit high in cycle 5, pkt_count = 1.
REQ-039 3-word packet with err = 1 on eop -> 3 words forwarded, p_abort pulse in the next cycle, drop_count = 1, pkt_count = 0.
REQ-040 max_len = 4, 7-word packet -> words 1-4 forwarded; word 5 consumed, not forwarded; p_abort next cycle; words 6-7 dropped with c_drdy = 1; then IDLE, drop_count = 1.
REQ-041 max_len = 4, 5-word packet with eop on word 5 -> abort pulse, return directly to IDLE, no DROP state.
REQ-042 Random p_drdy/c_srdy throttling over 100 mixed packets -> forwarded data matches the source, and pkt_count + drop_count = 100.
REQ-043 Reset asserted after word 2 of a 5-word packet -> no pulse, counters read 0, and the next packet commits normally.

Source files
------------

// File: rtl/sd_pkt_commit.sv
// sd_pkt_commit: forwards a packet stream into a commit-enabled FIFO and
// closes each packet with exactly one commit or abort pulse.
// Latency: data path is combinational (zero latency); p_commit/p_abort are
// registered and fire in the cycle after the packet's last accepted word.
// Backpressure: c_drdy follows p_drdy while forwarding; it is forced high for
// overflow and dropped words, and low in the COMMIT/ABORT cycle and in reset.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   c_srdy/c_drdy/c_data  - upstream word handshake and data
//   c_eop, c_err          - last-word marker; error flag sampled on eop only
//   p_srdy/p_drdy/p_data  - downstream (FIFO write side) handshake and data
//   p_commit, p_abort     - one-cycle pulses closing the packet in the FIFO
//   pkt_count, drop_count - wrapping counts of committed / aborted packets
module sd_pkt_commit #(
  parameter int width   = 8,
  parameter int max_len = 1518,
  parameter int lsz     = $clog2(max_len + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  input  logic             c_eop,
  input  logic             c_err,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic             p_commit,
  output logic             p_abort,
  output logic [15:0]      pkt_count,
  output logic [15:0]      drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_COMMIT,
    S_ABORT,
    S_DROP
  } state_t;

  localparam logic [lsz-1:0] LenMax = lsz'(max_len);
  localparam logic [lsz-1:0] LenOne = lsz'(1);

  state_t         state_q, state_d;
  logic [lsz-1:0] len_q, len_d;
  logic           drop_pend_q, drop_pend_d;
  logic           p_commit_q, p_commit_d;
  logic           p_abort_q, p_abort_d;
  logic [15:0]    pkt_count_q, pkt_count_d;
  logic [15:0]    drop_count_q, drop_count_d;

  // Data never needs holding here: the upstream source holds c_data during
  // stalls, so the downstream side simply sees it through.
  assign p_data     = c_data;
  assign p_commit   = p_commit_q;
  assign p_abort    = p_abort_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    drop_pend_d  = drop_pend_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    c_drdy       = 1'b0;
    p_srdy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        p_srdy = c_srdy;
        c_drdy = p_drdy;
        if (c_srdy && p_drdy) begin
          if (c_eop) begin
            state_d = c_err ? S_ABORT : S_COMMIT;
          end else begin
            state_d = S_ACTIVE;
            len_d   = LenOne;
          end
        end
      end

      S_ACTIVE: begin
        if (len_q == LenMax) begin
          // Overflow word: swallow it regardless of downstream readiness and
          // abort; the rest of the packet (if any) is dropped afterwards.
          c_drdy = 1'b1;
          if (c_srdy) begin
            state_d     = S_ABORT;
            drop_pend_d = !c_eop;
          end
        end else begin
          p_srdy = c_srdy;
          c_drdy = p_drdy;
          if (c_srdy && p_drdy) begin
            if (c_eop) begin
              state_d = c_err ? S_ABORT : S_COMMIT;
            end else begin
              len_d = len_q + LenOne;
            end
          end
        end
      end

      S_COMMIT: begin
        pkt_count_d = pkt_count_q + 16'd1;
        state_d     = S_IDLE;
      end

      S_ABORT: begin
        drop_count_d = drop_count_q + 16'd1;
        state_d      = drop_pend_q ? S_DROP : S_IDLE;
        drop_pend_d  = 1'b0;
      end

      S_DROP: begin
        c_drdy = 1'b1;
        if (c_srdy && c_eop) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      len_d = '0;
    end

    // Pulses are registered: they are high exactly while the state register
    // holds COMMIT or ABORT.
    p_commit_d = (state_d == S_COMMIT);
    p_abort_d  = (state_d == S_ABORT);

    if (reset) begin
      c_drdy = 1'b0;
      p_srdy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      drop_pend_q  <= 1'b0;
      p_commit_q   <= 1'b0;
      p_abort_q    <= 1'b0;
      pkt_count_q  <= 16'd0;
      drop_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      drop_pend_q  <= drop_pend_d;
      p_commit_q   <= p_commit_d;
      p_abort_q    <= p_abort_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule
